// File: rtl/recip_pkg.sv
// Shared types and constants for the iterative float32 reciprocal.
// Seed constants are Q2.FRAC_W fixed point, truncated toward zero.
package recip_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEED,
        MUL_A,
        MUL_B,
        PACK,
        DONE
    } state_t;

    localparam int FRAC_W_DEF = 30;
    localparam int EXP_W      = 8;
    localparam int MAN_W      = 23;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;
    localparam logic [31:0] INF  = 32'h7F80_0000;

    function automatic logic [63:0] seed_const(
        input int unsigned num,
        input int unsigned fw
    );
        return (64'(num) << fw) / 64'd17;
    endfunction

    localparam logic [63:0] C48_17 = seed_const(48, FRAC_W_DEF);
    localparam logic [63:0] C32_17 = seed_const(32, FRAC_W_DEF);

endpackage

// File: rtl/fp32_classify.sv
// Splits a float32 into fields and flags its special classes.
// Denormals are reported separately; the caller flushes them to zero.
module fp32_classify
    import recip_pkg::*;
(
    input  logic [31:0]      op,
    output logic             sign,
    output logic [EXP_W-1:0] expo,
    output logic [MAN_W-1:0] man,
    output logic             is_zero,
    output logic             is_denorm,
    output logic             is_inf,
    output logic             is_nan
);

    logic exp_min;
    logic exp_max;
    logic man_nz;

    assign sign = op[31];
    assign expo = op[30 -: EXP_W];
    assign man  = op[MAN_W-1:0];

    assign exp_min = (expo == '0);
    assign exp_max = (expo == '1);
    assign man_nz  = (man != '0);

    assign is_zero   = exp_min & ~man_nz;
    assign is_denorm = exp_min & man_nz;
    assign is_inf    = exp_max & ~man_nz;
    assign is_nan    = exp_max & man_nz;

endmodule

// File: rtl/recip_nr_iterative.sv
// Serial float32 reciprocal: Newton-Raphson refinement of a linear
// seed using a single shared multiplier, one half-iteration per cycle.
module recip_nr_iterative
    import recip_pkg::*;
#(
    parameter int ITER   = 3,
    parameter int FRAC_W = FRAC_W_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] recip,
    output logic        busy
);

    localparam int W  = FRAC_W + 2;
    localparam int PW = 2 * W;
    localparam int CW = 3;

    localparam logic [W-1:0] K48 = W'(seed_const(48, FRAC_W));
    localparam logic [W-1:0] K32 = W'(seed_const(32, FRAC_W));
    localparam logic [W-1:0] TWO = {2'b10, {FRAC_W{1'b0}}};

    state_t state;
    state_t state_n;

    logic [31:0]   op;
    logic [W-1:0]  d;
    logic [W-1:0]  x;
    logic [W-1:0]  t;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;

    logic             f_sign;
    logic [EXP_W-1:0] f_exp;
    logic [MAN_W-1:0] f_man;
    logic             f_zero;
    logic             f_denorm;
    logic             f_inf;
    logic             f_nan;

    fp32_classify u_classify (
        .op        (op),
        .sign      (f_sign),
        .expo      (f_exp),
        .man       (f_man),
        .is_zero   (f_zero),
        .is_denorm (f_denorm),
        .is_inf    (f_inf),
        .is_nan    (f_nan)
    );

    logic [W-1:0]  d_calc;
    logic [W-1:0]  two_minus_t;
    logic [W-1:0]  mul_a;
    logic [W-1:0]  mul_b;
    logic [PW-1:0] prod;
    logic [W-1:0]  prod_hi;
    logic [W-1:0]  prod_lo;
    logic          unused_prod;

    // D = 1.m / 2 in Q1.(FRAC_W+1)
    assign d_calc      = {1'b0, 1'b1, f_man, {(FRAC_W - MAN_W){1'b0}}};
    assign two_minus_t = TWO - t;
    assign cnt_inc     = cnt + 1'b1;

    always_comb begin
        mul_a = x;
        mul_b = d;
        if (state == SEED) begin
            mul_a = K32;
            mul_b = d_calc;
        end else if (state == MUL_B) begin
            mul_b = two_minus_t;
        end
    end

    // The only multiplier: Q2 x Q1 products drop FRAC_W+1 bits, Q2 x Q2 drop FRAC_W
    assign prod        = PW'(mul_a) * PW'(mul_b);
    assign prod_hi     = prod[FRAC_W+1 +: W];
    assign prod_lo     = prod[FRAC_W +: W];
    assign unused_prod = ^{prod[PW-1], prod[FRAC_W-1:0]};

    logic        flush_zero;
    logic        tiny;
    logic        special;
    logic [31:0] special_val;

    // Results whose exponent field would be <= 0 are known from e alone
    assign tiny = (f_exp == 8'hFE)
                | ((f_exp == 8'hFD) & (f_man != '0));
    assign flush_zero = f_zero | f_denorm;
    assign special    = f_nan | flush_zero | f_inf | tiny;

    always_comb begin
        special_val = {f_sign, 31'h0};
        if (f_nan) begin
            special_val = QNAN;
        end else if (flush_zero) begin
            special_val = {f_sign, INF[30:0]};
        end
    end

    int               e_res;
    logic [MAN_W-1:0] mant;
    logic [31:0]      pack_val;

    // Result is X * 2^(126-e); X normally lies in [1,2)
    always_comb begin
        e_res = 253 - int'(f_exp);
        mant  = x[FRAC_W-1 -: MAN_W];
        if (f_man == '0) begin
            e_res = 254 - int'(f_exp);
            mant  = '0;
        end else if (x[FRAC_W+1]) begin
            e_res = 254 - int'(f_exp);
            mant  = x[FRAC_W -: MAN_W];
        end else if (!x[FRAC_W]) begin
            e_res = 252 - int'(f_exp);
            mant  = x[FRAC_W-2 -: MAN_W];
        end
        if (e_res <= 0) begin
            pack_val = {f_sign, 31'h0};
        end else begin
            pack_val = {f_sign, e_res[EXP_W-1:0], mant};
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (in_valid) state_n = SEED;
            SEED:    state_n = special ? DONE : MUL_A;
            MUL_A:   state_n = MUL_B;
            MUL_B:   state_n = (cnt_inc == CW'(ITER)) ? PACK : MUL_A;
            PACK:    state_n = DONE;
            DONE:    if (out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op    <= '0;
            d     <= '0;
            x     <= '0;
            t     <= '0;
            cnt   <= '0;
            recip <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) op <= in;
                end
                SEED: begin
                    d   <= d_calc;
                    x   <= K48 - prod_hi;
                    cnt <= '0;
                    if (special) recip <= special_val;
                end
                MUL_A: begin
                    t <= prod_hi;
                end
                MUL_B: begin
                    x   <= prod_lo;
                    cnt <= cnt_inc;
                end
                PACK: begin
                    recip <= pack_val;
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_recip_nr_iterative.sv
// Bench for recip_nr_iterative: vector table with a result scoreboard,
// plus backpressure and mid-operation reset sequences.
module tb_recip_nr_iterative;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] opnd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] recip;
    logic        busy;

    recip_nr_iterative dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (opnd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .recip     (recip),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] r;
        int          tol;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] r;
        int          tol;
    } exp_t;

    localparam int NV = 14;

    vec_t vt[NV];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input longint got,
                         input longint want, input longint tol);
        longint d;
        checks++;
        d = got - want;
        if (d < 0) d = -d;
        if (d > tol) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] r,
                         input int tol);
        exp_t e;
        int   n;
        n = 0;
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_idle", in_ready, 1, 0);
        opnd     = a;
        in_valid = 1'b1;
        @(posedge clk);
        e.r   = r;
        e.tol = tol;
        sb.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic pop_check(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s got result want none queued", name);
        end else begin
            e = sb.pop_front();
            check(name, recip, e.r, e.tol);
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("out_valid_drop", out_valid, 0, 0);
        check("in_ready_back", in_ready, 1, 0);
    endtask

    int          lat;
    int          seen;
    logic [31:0] hold;

    initial begin
        vt[0]  = '{32'h4080_0000, 32'h3E80_0000, 0, 8};
        vt[1]  = '{32'hC000_0000, 32'hBF00_0000, 0, 8};
        vt[2]  = '{32'h41F8_0000, 32'h3D04_2108, 1, 8};
        vt[3]  = '{32'h4105_1EB8, 32'h3DF6_2762, 1, 8};
        vt[4]  = '{32'h3F80_0000, 32'h3F80_0000, 0, 8};
        vt[5]  = '{32'h3FC0_0000, 32'h3F2A_AAAB, 1, 8};
        vt[6]  = '{32'h0000_0000, 32'h7F80_0000, 0, 1};
        vt[7]  = '{32'h8000_0000, 32'hFF80_0000, 0, 1};
        vt[8]  = '{32'h7FC0_0001, 32'h7FC0_0000, 0, 1};
        vt[9]  = '{32'h7F80_0000, 32'h0000_0000, 0, 1};
        vt[10] = '{32'h7F00_0000, 32'h0000_0000, 0, 1};
        vt[11] = '{32'h0000_0001, 32'h7F80_0000, 0, 1};
        vt[12] = '{32'hFF80_0000, 32'h8000_0000, 0, 1};
        vt[13] = '{32'hC2C8_0000, 32'hBC23_D70A, 1, 8};

        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        opnd      = '0;
        #2 rst_n = 1'b0;
        #10;
        check("rst_in_ready", in_ready, 1, 0);
        check("rst_out_valid", out_valid, 0, 0);
        check("rst_recip", recip, 0, 0);
        check("rst_busy", busy, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            issue(vt[i].a, vt[i].r, vt[i].tol);
            check($sformatf("busy_run[%0d]", i), busy, 1, 0);
            wait_out(lat);
            check($sformatf("latency[%0d]", i), lat, vt[i].lat, 0);
            check($sformatf("in_ready_done[%0d]", i), in_ready, 0, 0);
            pop_check($sformatf("recip[%0d]", i));
            release_out();
        end

        // Backpressure: result held, new requests ignored
        issue(32'h41F8_0000, 32'h3D04_2108, 1);
        wait_out(lat);
        check("bp_latency", lat, 8, 0);
        hold     = recip;
        opnd     = 32'h4080_0000;
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            check($sformatf("bp_valid[%0d]", c), out_valid, 1, 0);
            check($sformatf("bp_stable[%0d]", c), recip, hold, 0);
            check($sformatf("bp_in_ready[%0d]", c), in_ready, 0, 0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        pop_check("bp_recip");
        release_out();
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("bp_ignored_req", seen, 0, 0);

        // Reset while in MUL_B aborts the operation
        issue(32'h4105_1EB8, 32'h3DF6_2762, 1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", out_valid, 0, 0);
        check("abort_in_ready", in_ready, 1, 0);
        check("abort_busy", busy, 0, 0);
        check("abort_recip", recip, 0, 0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("abort_no_stale", seen, 0, 0);

        issue(32'h4080_0000, 32'h3E80_0000, 0);
        wait_out(lat);
        check("recover_latency", lat, 8, 0);
        pop_check("recover_recip");
        release_out();
        check("sb_empty", sb.size(), 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
